// File: rtl/prach_rtc_id_lut.sv
// prach_rtc_id_lut: programmable RTC ID table returning the (cc, ant) index of a matching entry.
module prach_rtc_id_lut #(
  parameter int NUM_CC = 3,
  parameter int NUM_ANT = 8,
  parameter int ANT_PER_BAND = 4,
  parameter int ID_W = 16,
  localparam int N = NUM_CC * NUM_ANT,
  localparam int AW = N > 1 ? $clog2(N) : 1,
  localparam int CW = NUM_CC > 1 ? $clog2(NUM_CC) : 1,
  localparam int TW = NUM_ANT > 1 ? $clog2(NUM_ANT) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [ID_W-1:0] cfg_id,
  input  logic            cfg_en,
  output logic            cfg_err,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [ID_W-1:0] s_rtc_id,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_hit,
  output logic            m_dup,
  output logic [CW-1:0]   m_cc,
  output logic [TW-1:0]   m_ant,
  output logic [ID_W-1:0] m_rtc_id,
  output logic [15:0]     miss_cnt,
  input  logic            miss_cnt_clr
);
  logic [ID_W-1:0] ids [N];
  logic [N-1:0] en, match, s1Match;
  logic s1Valid, s2Adv;
  logic [ID_W-1:0] s1Id;
  logic [CW-1:0] encCc;
  logic [TW-1:0] encAnt;

  function automatic logic [ID_W-1:0] defId(input int i);
    int a;
    a = i % NUM_ANT;
    return ID_W'({4'h0, 4'(a / ANT_PER_BAND), 4'(i / NUM_ANT), 4'(a % ANT_PER_BAND)});
  endfunction

  assign s2Adv = !m_valid || m_ready;
  assign s_ready = !s1Valid || s2Adv;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        ids[i] <= defId(i);
        en[i] <= 1'b1;
      end
    end else if (cfg_we && int'(cfg_addr) < N) begin
      ids[cfg_addr] <= cfg_id;
      en[cfg_addr] <= cfg_en;
    end

  always_comb begin
    match = '0;
    for (int i = 0; i < N; i++) match[i] = en[i] && ids[i] == s_rtc_id;
  end

  // descending scan leaves the lowest matching index
  always_comb begin
    encCc = '0;
    encAnt = '0;
    for (int i = N - 1; i >= 0; i--)
      if (s1Match[i]) begin
        encCc = CW'(i / NUM_ANT);
        encAnt = TW'(i % NUM_ANT);
      end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1Valid <= 1'b0;
      s1Id <= '0;
      s1Match <= '0;
      m_valid <= 1'b0;
      m_hit <= 1'b0;
      m_dup <= 1'b0;
      m_cc <= '0;
      m_ant <= '0;
      m_rtc_id <= '0;
      cfg_err <= 1'b0;
      miss_cnt <= '0;
    end else begin
      cfg_err <= cfg_we && int'(cfg_addr) >= N;
      if (s_ready) begin
        s1Valid <= s_valid;
        if (s_valid) begin
          s1Id <= s_rtc_id;
          s1Match <= match;
        end
      end
      if (s2Adv) begin
        m_valid <= s1Valid;
        if (s1Valid) begin
          m_hit <= |s1Match;
          m_dup <= |(s1Match & (s1Match - N'(1)));
          m_cc <= encCc;
          m_ant <= encAnt;
          m_rtc_id <= s1Id;
        end
      end
      miss_cnt <= miss_cnt_clr ? 16'h0 :
                  (m_valid && m_ready && !m_hit && miss_cnt != 16'hFFFF) ? miss_cnt + 16'd1 : miss_cnt;
    end
endmodule

// File: tb/tb_prach_rtc_id_lut.sv
// tb_prach_rtc_id_lut: directed checks of the RTC ID lookup table and its result pipeline.
module tb_prach_rtc_id_lut;
  logic clk, rst_n, cfg_we, cfg_en, cfg_err, s_valid, s_ready, m_valid, m_ready, m_hit, m_dup, miss_cnt_clr;
  logic [4:0] cfg_addr;
  logic [15:0] cfg_id, s_rtc_id, m_rtc_id, miss_cnt;
  logic [1:0] m_cc;
  logic [2:0] m_ant;
  logic [22:0] res;
  logic [15:0] t5Id [6];
  logic [22:0] t5Exp [6];
  int checks = 0, errors = 0, sent, recv;
  bit acc, xfer;

  assign res = {m_hit, m_dup, m_cc, m_ant, m_rtc_id};

  prach_rtc_id_lut dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_id(cfg_id), .cfg_en(cfg_en),
    .cfg_err(cfg_err), .s_valid(s_valid), .s_ready(s_ready), .s_rtc_id(s_rtc_id), .m_valid(m_valid),
    .m_ready(m_ready), .m_hit(m_hit), .m_dup(m_dup), .m_cc(m_cc), .m_ant(m_ant), .m_rtc_id(m_rtc_id),
    .miss_cnt(miss_cnt), .miss_cnt_clr(miss_cnt_clr)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [15:0] id, input logic [22:0] exp, input bit clr);
    m_ready = 1;
    s_valid = 1;
    s_rtc_id = id;
    #1;
    check({tag, ":rdy"}, 32'(s_ready), 1);
    tick();
    s_valid = 0;
    check({tag, ":lat"}, 32'(m_valid), 0);
    tick();
    check({tag, ":vld"}, 32'(m_valid), 1);
    check({tag, ":res"}, 32'(res), 32'(exp));
    miss_cnt_clr = clr;
    tick();
    miss_cnt_clr = 0;
  endtask

  task automatic cfgWrite(input logic [4:0] addr, input logic [15:0] id, input logic en);
    cfg_we = 1;
    cfg_addr = addr;
    cfg_id = id;
    cfg_en = en;
    tick();
    cfg_we = 0;
    check("cfg_err", 32'(cfg_err), 32'(addr >= 24));
    tick();
    check("cfg_err_pulse", 32'(cfg_err), 0);
  endtask

  initial begin
    rst_n = 0; cfg_we = 0; cfg_addr = 0; cfg_id = 0; cfg_en = 0;
    s_valid = 0; s_rtc_id = 0; m_ready = 1; miss_cnt_clr = 0;
    #1;
    check("rst_res", 32'(res), 0);
    check("rst_vld", 32'(m_valid), 0);
    check("rst_miss", 32'(miss_cnt), 0);
    check("rst_err", 32'(cfg_err), 0);
    check("rst_rdy", 32'(s_ready), 1);
    repeat (2) tick();
    rst_n = 1;
    tick();

    lookup("t1a", 16'h0112, {1'b1, 1'b0, 2'd1, 3'd6, 16'h0112}, 0);
    lookup("t1b", 16'h0120, {1'b1, 1'b0, 2'd2, 3'd4, 16'h0120}, 0);
    lookup("t1c", 16'h0003, {1'b1, 1'b0, 2'd0, 3'd3, 16'h0003}, 0);
    check("t1miss", 32'(miss_cnt), 0);

    lookup("t2a", 16'h0030, {1'b0, 1'b0, 2'd0, 3'd0, 16'h0030}, 0);
    check("t2cnt1", 32'(miss_cnt), 1);
    s_valid = 1;
    s_rtc_id = 16'h0030;
    repeat (65533) tick();
    s_valid = 0;
    repeat (3) tick();
    check("t2fffe", 32'(miss_cnt), 32'h0000FFFE);
    s_valid = 1;
    repeat (5) tick();
    s_valid = 0;
    repeat (3) tick();
    check("t2sat", 32'(miss_cnt), 32'h0000FFFF);
    lookup("t2clr", 16'h0030, {1'b0, 1'b0, 2'd0, 3'd0, 16'h0030}, 1);
    check("t2clrcnt", 32'(miss_cnt), 0);

    cfgWrite(5'd8, 16'h0000, 1);
    lookup("t3dup", 16'h0000, {1'b1, 1'b1, 2'd0, 3'd0, 16'h0000}, 0);
    cfgWrite(5'd0, 16'h0000, 0);
    lookup("t3dis", 16'h0000, {1'b1, 1'b0, 2'd1, 3'd0, 16'h0000}, 0);
    cfgWrite(5'd24, 16'h0112, 0);
    lookup("t3oor", 16'h0112, {1'b1, 1'b0, 2'd1, 3'd6, 16'h0112}, 0);
    check("t3miss", 32'(miss_cnt), 0);

    cfg_we = 1; cfg_addr = 5'd5; cfg_id = 16'hABCD; cfg_en = 1;
    s_valid = 1; s_rtc_id = 16'hABCD;
    tick();
    cfg_we = 0; s_valid = 0;
    tick();
    check("t4race_vld", 32'(m_valid), 1);
    check("t4race", 32'(res), 32'({1'b0, 1'b0, 2'd0, 3'd0, 16'hABCD}));
    tick();
    check("t4cnt", 32'(miss_cnt), 1);
    lookup("t4hit", 16'hABCD, {1'b1, 1'b0, 2'd0, 3'd5, 16'hABCD}, 0);

    t5Id[0] = 16'h0112; t5Exp[0] = {1'b1, 1'b0, 2'd1, 3'd6, 16'h0112};
    t5Id[1] = 16'h0030; t5Exp[1] = {1'b0, 1'b0, 2'd0, 3'd0, 16'h0030};
    t5Id[2] = 16'h0020; t5Exp[2] = {1'b1, 1'b0, 2'd2, 3'd0, 16'h0020};
    t5Id[3] = 16'h0103; t5Exp[3] = {1'b1, 1'b0, 2'd0, 3'd7, 16'h0103};
    t5Id[4] = 16'hABCD; t5Exp[4] = {1'b1, 1'b0, 2'd0, 3'd5, 16'hABCD};
    t5Id[5] = 16'h0000; t5Exp[5] = {1'b1, 1'b0, 2'd1, 3'd0, 16'h0000};
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 300 && recv < 6; cyc++) begin
      m_ready = cyc < 5 ? 1'b0 : 1'($urandom_range(0, 1));
      s_valid = sent < 6;
      s_rtc_id = t5Id[sent < 6 ? sent : 0];
      #1;
      if (cyc < 5) check("t5rdy", 32'(s_ready), 32'(sent < 2));
      if (m_valid) check("t5res", 32'(res), recv < 6 ? 32'(t5Exp[recv]) : 32'hFFFFFFFF);
      acc = s_valid && s_ready;
      xfer = m_valid && m_ready;
      tick();
      sent += int'(acc);
      recv += int'(xfer);
    end
    s_valid = 0;
    m_ready = 1;
    check("t5count", recv, 6);
    tick();
    check("t5drain", 32'(m_valid), 0);

    cfgWrite(5'd14, 16'hBEEF, 1);
    m_ready = 0;
    s_valid = 1;
    s_rtc_id = 16'h0112;
    tick();
    s_rtc_id = 16'h0020;
    tick();
    s_valid = 0;
    check("t6held", 32'(m_valid), 1);
    check("t6rdy", 32'(s_ready), 0);
    #2 rst_n = 0;
    #1;
    check("t6flush", 32'(m_valid), 0);
    check("t6miss", 32'(miss_cnt), 0);
    check("t6rdyrst", 32'(s_ready), 1);
    repeat (2) tick();
    rst_n = 1;
    m_ready = 1;
    tick();
    check("t6noout", 32'(m_valid), 0);
    lookup("t6hit", 16'h0112, {1'b1, 1'b0, 2'd1, 3'd6, 16'h0112}, 0);
    check("t6cnt", 32'(miss_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
